pll_reconfig_ctrl: RTL and testbench
====================================

Name: pll_reconfig_ctrl

Overview:
Management-side controller that drives the 64-bit reconfig_to_pll bus and consumes the reconfig_from_pll bus of the system PLL wrapper.
- Host (HPS/Avalon-MM bridge) programs shadow M, N and C counter registers, then writes START.
- The block replays only the changed ("dirty") counters to the PLL's management port, triggers reconfiguration, and waits for re-lock with a timeout.
- Sits between the lightweight HPS bridge and the PLL instance.

Parameters:
NUM_C, 18, number of output C counters addressable (index 0..NUM_C-1)
LOCK_TIMEOUT, 65535, cycles to wait for locked after PLL busy drops, before flagging error

Ports:
clk  in  1  management clock; also drives the PLL management interface
rst  in  1  asynchronous, active-high reset
avs_address  in  3  host register address
avs_write  in  1  host write strobe
avs_writedata  in  32  host write data
avs_read  in  1  host read strobe
avs_readdata  out  32  host read data, valid 1 cycle after avs_read
reconfig_to_pll  out  64  [0] mgmt_write, [1] mgmt_read, [7:2] mgmt_address, [39:8] mgmt_writedata, [63:40] zero
reconfig_from_pll  in  64  [31:0] mgmt_readdata, [32] mgmt_waitrequest, [33] pll locked, rest ignored
irq  out  1  level high while STATUS.done or STATUS.error is set

Behaviour:
Register map (avs_address):
- 0 CTRL: write bit0=1 → start; bit1=1 → clear done/error.
- 1 STATUS (RO): [0] busy, [1] done, [2] error, [3] live locked.
- 2 M, 3 N, each 32 bits:
  - [7:0] hi_div, [15:8] lo_div, [16] bypass, [17] odd_duty
  - each write sets that register's dirty bit.
- 4 C: same fields plus [22:18] counter index.
  - A write stores one entry in a NUM_C-deep shadow array and sets that entry's dirty bit.
  - Index >= NUM_C is ignored.
- 5 TIMEOUT_CNT (RO): cycles spent in the last lock wait.

Host side:
- Writes to addresses 2-4 while busy are dropped (no stall).
- START while busy is ignored.

PLL management addresses:
- M → 4; N → 3; C → 5, data = shadow value with index in [22:18]; START → 2, data 1.

Write handshake:
- mgmt_write and address/data are held until a cycle with mgmt_write=1 and mgmt_waitrequest=0.
- mgmt_write deasserts the next cycle.
- mgmt_read is always 0.

FSM:
- IDLE → WR_M on start.
- WR_M: skipped if M not dirty → WR_N.
- WR_N: skipped if not dirty → WR_C.
- WR_C: scans indices 0..NUM_C-1 ascending and writes dirty entries only. One clean index costs one cycle.
- WR_START → WAIT_BUSY.
- WAIT_BUSY: waits for mgmt_waitrequest=0. If it is already 0 the wait takes 1 cycle.
- WAIT_LOCK: counter from 0.
  - locked=1 → DONE.
  - counter reaches LOCK_TIMEOUT → ERR.
- DONE/ERR: set the status bit, clear all dirty bits → IDLE.
- Dirty bits clear only on DONE/ERR. A failed attempt still clears them.
- No dirty registers at start: the START write is still issued (null reconfiguration).

Simultaneous events:
- clear and start in the same CTRL write: clear applies first, then start.
- done/error and clear in the same cycle: the new done/error wins.
- busy=1 from the start cycle +1 until the DONE/ERR cycle, inclusive.

Reset (async):
- All shadow registers = 0; dirty bits = 0; FSM = IDLE.
- reconfig_to_pll = 0; avs_readdata = 0; irq = 0; STATUS = 0 except live locked.
- Reset mid-sequence aborts immediately, with no completion of the pending PLL write.

Test Plan:
- Reset released, read STATUS → 0x0 or 0x8 per locked; reconfig_to_pll = 0; irq = 0.
- Write M=0x0000_0C0C, C idx 0 = 0x0000_3030, start, PLL waitrequest low, locked high 10 cycles after START → bus writes addr4/0x0C0C, then addr5/0x3030, then addr2/1; done=1, irq=1; TIMEOUT_CNT = 10 ±1.
- Hold mgmt_waitrequest high 5 cycles during the M write → write, address and data stable all 5 cycles; exactly one accepted write; sequence then continues.
- LOCK_TIMEOUT=100, locked stays 0 → error=1, done=0, irq=1 at 100 cycles; dirty bits cleared, so a second start issues only addr2.
- Write N during busy, and start during busy → N shadow unchanged and no second sequence; CTRL clear → irq=0.
- Assert rst during WR_C → reconfig_to_pll = 0 within the same cycle; STATUS = 0 (plus live locked); a new start after release issues only addr2.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: host-programmed shadow M/N/C counters are replayed
// (dirty entries only) to the PLL management port, then re-lock is awaited with a timeout.
module pll_reconfig_ctrl #(
    parameter int unsigned NUM_C        = 18,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [63:0] reconfig_to_pll,
    input  logic [63:0] reconfig_from_pll,
    output logic        irq
);

    localparam int unsigned IdxW = 5;

    typedef enum logic [3:0] {
        StIdle,
        StWrM,
        StWrN,
        StWrC,
        StWrStart,
        StWaitBusy,
        StWaitLock,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [17:0]      m_q, n_q;
    logic             m_dirty_q, n_dirty_q;
    logic [17:0]      c_q [NUM_C];
    logic [NUM_C-1:0] c_dirty_q;

    logic [IdxW-1:0]  c_idx_q, c_idx_d;
    logic             wr_done_q, wr_done_d;
    logic [31:0]      lock_cnt_q, lock_cnt_d;
    logic [31:0]      timeout_cnt_q, timeout_cnt_d;
    logic             done_q, error_q;
    logic [31:0]      readdata_q;

    logic             mgmt_write;
    logic [5:0]       mgmt_addr;
    logic [31:0]      mgmt_wdata;
    logic             mgmt_waitreq;
    logic             pll_locked;
    logic             wr_accept;

    logic             busy;
    logic             host_wr;
    logic             ctrl_wr;
    logic             start;
    logic             clear;
    logic [IdxW-1:0]  c_wr_idx;
    logic             c_wr_ok;
    logic             unused_inputs;

    assign mgmt_waitreq  = reconfig_from_pll[32];
    assign pll_locked    = reconfig_from_pll[33];
    assign unused_inputs = ^{reconfig_from_pll[63:34], reconfig_from_pll[31:0],
                             avs_writedata[31:23]};

    assign busy     = (state_q != StIdle);
    // Shadow registers only accept writes while no sequence is in flight.
    assign host_wr  = avs_write && !busy;
    assign ctrl_wr  = avs_write && (avs_address == 3'd0);
    assign start    = ctrl_wr && avs_writedata[0] && !busy;
    assign clear    = ctrl_wr && avs_writedata[1];
    assign c_wr_idx = avs_writedata[22:18];
    assign c_wr_ok  = ({27'b0, c_wr_idx} < NUM_C);

    assign wr_accept = mgmt_write && !mgmt_waitreq;

    // Shadow counter registers and their dirty bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            n_q       <= '0;
            m_dirty_q <= 1'b0;
            n_dirty_q <= 1'b0;
            c_dirty_q <= '0;
            for (int i = 0; i < NUM_C; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            if (host_wr && avs_address == 3'd2) begin
                m_q       <= avs_writedata[17:0];
                m_dirty_q <= 1'b1;
            end
            if (host_wr && avs_address == 3'd3) begin
                n_q       <= avs_writedata[17:0];
                n_dirty_q <= 1'b1;
            end
            if (host_wr && avs_address == 3'd4 && c_wr_ok) begin
                c_q[c_wr_idx]       <= avs_writedata[17:0];
                c_dirty_q[c_wr_idx] <= 1'b1;
            end
            // A finished attempt, good or bad, consumes every pending change.
            if (state_q == StDone || state_q == StErr) begin
                m_dirty_q <= 1'b0;
                n_dirty_q <= 1'b0;
                c_dirty_q <= '0;
            end
        end
    end

    // Status bits: a completion in the same cycle as a clear takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (clear) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (state_q == StDone) begin
                done_q  <= 1'b1;
                error_q <= 1'b0;
            end
            if (state_q == StErr) begin
                error_q <= 1'b1;
                done_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q <= '0;
        end else if (avs_read) begin
            case (avs_address)
                3'd1:    readdata_q <= {28'b0, pll_locked, error_q, done_q, busy};
                3'd2:    readdata_q <= {14'b0, m_q};
                3'd3:    readdata_q <= {14'b0, n_q};
                3'd5:    readdata_q <= timeout_cnt_q;
                default: readdata_q <= '0;
            endcase
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = done_q | error_q;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            c_idx_q       <= '0;
            wr_done_q     <= 1'b0;
            lock_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            c_idx_q       <= c_idx_d;
            wr_done_q     <= wr_done_d;
            lock_cnt_q    <= lock_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // FSM: next state. wr_done_q marks the idle cycle that follows an accepted write.
    always_comb begin
        state_d       = state_q;
        c_idx_d       = c_idx_q;
        wr_done_d     = wr_done_q;
        lock_cnt_d    = lock_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWrM;
                    c_idx_d   = '0;
                    wr_done_d = 1'b0;
                end
            end
            StWrM: begin
                if (!m_dirty_q || wr_done_q) begin
                    state_d   = StWrN;
                    wr_done_d = 1'b0;
                end else if (wr_accept) begin
                    wr_done_d = 1'b1;
                end
            end
            StWrN: begin
                if (!n_dirty_q || wr_done_q) begin
                    state_d   = StWrC;
                    wr_done_d = 1'b0;
                end else if (wr_accept) begin
                    wr_done_d = 1'b1;
                end
            end
            StWrC: begin
                if (!c_dirty_q[c_idx_q] || wr_done_q) begin
                    wr_done_d = 1'b0;
                    if (c_idx_q == IdxW'(NUM_C - 1)) begin
                        state_d = StWrStart;
                    end else begin
                        c_idx_d = c_idx_q + 1'b1;
                    end
                end else if (wr_accept) begin
                    wr_done_d = 1'b1;
                end
            end
            StWrStart: begin
                if (wr_done_q) begin
                    state_d   = StWaitBusy;
                    wr_done_d = 1'b0;
                end else if (wr_accept) begin
                    wr_done_d = 1'b1;
                end
            end
            StWaitBusy: begin
                lock_cnt_d = '0;
                if (!mgmt_waitreq) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                // timeout_cnt counts cycles spent in this state, including the exit cycle.
                lock_cnt_d = lock_cnt_q + 32'd1;
                if (pll_locked) begin
                    timeout_cnt_d = lock_cnt_q + 32'd1;
                    state_d       = StDone;
                end else if (lock_cnt_q + 32'd1 == LOCK_TIMEOUT) begin
                    timeout_cnt_d = LOCK_TIMEOUT;
                    state_d       = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs, decoded from registered state only so reset clears the bus at once.
    always_comb begin
        mgmt_write = 1'b0;
        mgmt_addr  = '0;
        mgmt_wdata = '0;
        case (state_q)
            StWrM: begin
                mgmt_write = m_dirty_q && !wr_done_q;
                mgmt_addr  = 6'd4;
                mgmt_wdata = {14'b0, m_q};
            end
            StWrN: begin
                mgmt_write = n_dirty_q && !wr_done_q;
                mgmt_addr  = 6'd3;
                mgmt_wdata = {14'b0, n_q};
            end
            StWrC: begin
                mgmt_write = c_dirty_q[c_idx_q] && !wr_done_q;
                mgmt_addr  = 6'd5;
                mgmt_wdata = {9'b0, c_idx_q, c_q[c_idx_q]};
            end
            StWrStart: begin
                mgmt_write = !wr_done_q;
                mgmt_addr  = 6'd2;
                mgmt_wdata = 32'd1;
            end
            default: begin
                mgmt_write = 1'b0;
            end
        endcase
        if (!mgmt_write) begin
            mgmt_addr  = '0;
            mgmt_wdata = '0;
        end
    end

    assign reconfig_to_pll = {24'b0, mgmt_wdata, mgmt_addr, 1'b0, mgmt_write};

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: register table checks plus multi-cycle sequences
// against a simple PLL model (waitrequest/locked driven by the bench).
module tb_pll_reconfig_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [63:0] reconfig_to_pll;
    logic [63:0] reconfig_from_pll;
    logic        irq;
    logic        waitreq;
    logic        locked;

    int total = 0;
    int bad   = 0;
    int bus_err = 0;

    logic [37:0] acc_q [$];
    logic [37:0] exp_q [$];

    assign reconfig_from_pll = {30'b0, locked, waitreq, 32'hDEAD_BEEF};

    pll_reconfig_ctrl #(
        .NUM_C        (18),
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .reconfig_to_pll   (reconfig_to_pll),
        .reconfig_from_pll (reconfig_from_pll),
        .irq               (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: inputs change on negedge, sampled 2ns later, accepted on next posedge.
    always begin
        @(negedge clk);
        #2;
        if (reconfig_to_pll[1] !== 1'b0 || reconfig_to_pll[63:40] !== 24'b0) bus_err++;
        if (reconfig_to_pll[0] === 1'b1 && waitreq === 1'b0)
            acc_q.push_back({reconfig_to_pll[7:2], reconfig_to_pll[39:8]});
    end

    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic check_writes(input string name);
        chk({name, "_count"}, 64'(acc_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk({name, "_entry"}, 64'(acc_q[i]), 64'(exp_q[i]));
    endtask

    // Waits for the START write, then models PLL busy for a few cycles and asserts
    // locked lock_delay cycles after busy drops (0 = never), then waits for irq.
    task automatic run_pll(input int lock_delay);
        bit seen = 0;
        bit irq_seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (reconfig_to_pll[0] && reconfig_to_pll[7:2] == 6'd2 && !waitreq) seen = 1;
        end
        chk("start_write_seen", 64'(seen), 64'd1);
        @(negedge clk);
        waitreq = 1'b1;
        repeat (3) @(negedge clk);
        waitreq = 1'b0;
        if (lock_delay > 0) begin
            @(posedge clk);
            repeat (lock_delay - 1) @(posedge clk);
            @(negedge clk);
            locked = 1'b1;
        end
        for (int i = 0; i < 300 && !irq_seen; i++) begin
            @(negedge clk);
            if (irq) irq_seen = 1;
        end
        chk("irq_seen", 64'(irq_seen), 64'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [63:0] snap;
        bit          seen;
        bit          stable;

        vecs[0] = '{3'd2, 32'h0000_0C0C, 3'd2, 32'h0000_0C0C};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 3'd2, 32'h0003_FFFF};
        vecs[2] = '{3'd3, 32'h0001_2345, 3'd3, 32'h0001_2345};
        vecs[3] = '{3'd3, 32'hABCD_EF01, 3'd3, 32'h0001_EF01};
        vecs[4] = '{3'd4, 32'h0000_1234, 3'd4, 32'h0000_0000};
        vecs[5] = '{3'd0, 32'h0000_0002, 3'd1, 32'h0000_0000};
        vecs[6] = '{3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000};
        vecs[7] = '{3'd6, 32'h0000_1234, 3'd6, 32'h0000_0000};
        vecs[8] = '{3'd1, 32'h0000_000F, 3'd1, 32'h0000_0000};
        vecs[9] = '{3'd2, 32'h0003_0000, 3'd2, 32'h0003_0000};

        rst = 1'b1; avs_address = '0; avs_write = 0; avs_writedata = '0; avs_read = 0;
        waitreq = 1'b0; locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_to_pll", reconfig_to_pll, 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_readdata", 64'(avs_readdata), 64'd0);
        rst = 1'b0;
        host_read(3'd1, rd);
        chk("status_after_rst", 64'(rd), 64'h0);
        locked = 1'b1;
        host_read(3'd1, rd);
        chk("status_locked", 64'(rd), 64'h8);
        locked = 1'b0;

        // Register table while idle
        foreach (vecs[i]) begin
            host_write(vecs[i].waddr, vecs[i].wdata);
            host_read(vecs[i].raddr, rd);
            chk($sformatf("vec%0d", i), 64'(rd), 64'(vecs[i].exp));
        end

        // Reset clears the shadows and dirty bits left by the table
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        host_read(3'd2, rd);
        chk("m_after_rst", 64'(rd), 64'h0);

        // Basic sequence: M, C0, out-of-range C20 (ignored), last index C17
        host_write(3'd2, 32'h0000_0C0C);
        host_write(3'd4, 32'h0000_3030);
        host_write(3'd4, (32'd20 << 18) | 32'h77);
        host_write(3'd4, (32'd17 << 18) | 32'h55);
        acc_q.delete();
        exp_q = '{{6'd4, 32'h0000_0C0C}, {6'd5, 32'h0000_3030},
                  {6'd5, 32'h0044_0055}, {6'd2, 32'h0000_0001}};
        host_write(3'd0, 32'h1);
        run_pll(10);
        check_writes("basic");
        host_read(3'd1, rd);
        chk("basic_status", 64'(rd), 64'hA);
        chk("basic_irq", 64'(irq), 64'd1);
        host_read(3'd5, rd);
        chk("basic_timeout_cnt", 64'(rd), 64'd10);

        // Clear, then stall the M write with waitrequest
        host_write(3'd0, 32'h2);
        chk("clear_irq", 64'(irq), 64'd0);
        locked = 1'b0;
        host_write(3'd2, 32'h0000_0555);
        acc_q.delete();
        exp_q = '{{6'd4, 32'h0000_0555}, {6'd2, 32'h0000_0001}};
        waitreq = 1'b1;
        host_write(3'd0, 32'h1);
        seen = 0; snap = '0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (reconfig_to_pll[0]) begin seen = 1; snap = reconfig_to_pll; end
        end
        chk("stall_write_seen", 64'(seen), 64'd1);
        chk("stall_bus", snap, {24'b0, 32'h0000_0555, 6'd4, 2'b01});
        stable = 1;
        repeat (4) begin
            @(negedge clk);
            #2;
            if (reconfig_to_pll !== snap) stable = 0;
        end
        chk("stall_stable", 64'(stable), 64'd1);
        @(negedge clk);
        waitreq = 1'b0;
        run_pll(10);
        check_writes("stall");

        // Lock timeout
        host_write(3'd0, 32'h2);
        locked = 1'b0;
        host_write(3'd3, 32'h0000_0707);
        acc_q.delete();
        exp_q = '{{6'd3, 32'h0000_0707}, {6'd2, 32'h0000_0001}};
        host_write(3'd0, 32'h1);
        run_pll(0);
        check_writes("timeout");
        host_read(3'd1, rd);
        chk("timeout_status", 64'(rd), 64'h4);
        host_read(3'd5, rd);
        chk("timeout_cnt", 64'(rd), 64'd100);

        // Clear+start together after the failure: dirty bits are gone, null reconfig
        acc_q.delete();
        exp_q = '{{6'd2, 32'h0000_0001}};
        host_write(3'd0, 32'h3);
        run_pll(10);
        check_writes("null_reconfig");
        host_read(3'd1, rd);
        chk("null_status", 64'(rd), 64'hA);

        // Writes and START while busy are dropped
        host_write(3'd0, 32'h2);
        locked = 1'b0;
        acc_q.delete();
        exp_q = '{{6'd2, 32'h0000_0001}};
        host_write(3'd0, 32'h1);
        host_write(3'd3, 32'h0000_1111);
        host_write(3'd0, 32'h1);
        host_read(3'd1, rd);
        chk("busy_status", 64'(rd), 64'h1);
        run_pll(10);
        repeat (40) @(negedge clk);
        check_writes("busy_drop");
        host_read(3'd3, rd);
        chk("busy_n_kept", 64'(rd), 64'h707);
        host_write(3'd0, 32'h2);
        chk("busy_clear_irq", 64'(irq), 64'd0);

        // Reset in the middle of a stalled C write
        host_write(3'd4, (32'd3 << 18) | 32'hAA);
        acc_q.delete();
        waitreq = 1'b1;
        host_write(3'd0, 32'h1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (reconfig_to_pll[0] && reconfig_to_pll[7:2] == 6'd5) seen = 1;
        end
        chk("rstmid_c_seen", 64'(seen), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_to_pll", reconfig_to_pll, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        waitreq = 1'b0;
        locked = 1'b1;
        host_read(3'd1, rd);
        chk("rstmid_status", 64'(rd), 64'h8);
        chk("rstmid_irq", 64'(irq), 64'd0);
        locked = 1'b0;
        acc_q.delete();
        exp_q = '{{6'd2, 32'h0000_0001}};
        host_write(3'd0, 32'h1);
        run_pll(10);
        check_writes("rstmid_restart");

        chk("bus_read_and_upper_zero", 64'(bus_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
